// File: rtl/airlock_controller_pkg.sv
// rtl/airlock_controller_pkg.sv - airlock state encodings and state-derived status helpers
package airlock_controller_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY      = 3'd0,
    ST_OUTER_OPEN = 3'd1,
    ST_FILLING    = 3'd2,
    ST_FULL       = 3'd3,
    ST_INNER_OPEN = 3'd4,
    ST_DRAINING   = 3'd5
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == ST_FILLING) || (s == ST_DRAINING);
  endfunction

  // Chamber holds inner-side condition until a drain actually completes.
  function automatic logic is_pressurized(state_t s);
    return (s == ST_FULL) || (s == ST_INNER_OPEN) || (s == ST_DRAINING);
  endfunction

endpackage

// File: rtl/airlock_controller_if.sv
// rtl/airlock_controller_if.sv - request inputs and status outputs of the airlock controller
interface airlock_controller_if #(parameter int CNT_W = 4);
  logic             outer_req;
  logic             inner_req;
  logic             fill_req;
  logic             drain_req;
  logic             outer_open;
  logic             inner_open;
  logic             pressurized;
  logic             busy;
  logic             reject;
  logic [CNT_W-1:0] countdown;
  logic [2:0]       state;

  modport master (
    output outer_req, inner_req, fill_req, drain_req,
    input  outer_open, inner_open, pressurized, busy, reject, countdown, state
  );

  modport slave (
    input  outer_req, inner_req, fill_req, drain_req,
    output outer_open, inner_open, pressurized, busy, reject, countdown, state
  );
endinterface

// File: rtl/airlock_timer.sv
// rtl/airlock_timer.sv - loadable fill/drain countdown; reaching 0 from 1 is the expiry step
module airlock_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - CNT_W'(1);
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/airlock_controller.sv
// rtl/airlock_controller.sv - airlock interlock FSM with port edge detect and reject generation
module airlock_controller
  import airlock_controller_pkg::*;
#(
  parameter int FILL_CYCLES  = 5,
  parameter int DRAIN_CYCLES = 7,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  airlock_controller_if.slave bus
);

  state_t           state, nxt;
  logic             outer_q, inner_q;
  logic             outer_rise, inner_rise;
  logic             rej, tload, tdone;
  logic [CNT_W-1:0] tval, count;

  assign outer_rise = bus.outer_req & ~outer_q;
  assign inner_rise = bus.inner_req & ~inner_q;

  // A simultaneous fill+drain is never treated as an abort; the timer keeps running.
  always_comb begin
    nxt   = state;
    rej   = 1'b0;
    tload = 1'b0;
    tval  = '0;
    case (state)
      ST_EMPTY: begin
        rej = inner_rise | bus.drain_req;
        if (bus.outer_req) begin
          nxt = ST_OUTER_OPEN;
          rej = rej | bus.fill_req;
        end else if (bus.fill_req && !bus.drain_req) begin
          nxt   = ST_FILLING;
          tload = 1'b1;
          tval  = CNT_W'(FILL_CYCLES);
        end else begin
          rej = rej | bus.fill_req;
        end
      end
      ST_OUTER_OPEN: begin
        rej = bus.fill_req | bus.drain_req | inner_rise;
        if (!bus.outer_req) nxt = ST_EMPTY;
      end
      ST_FILLING: begin
        rej = bus.fill_req | outer_rise | inner_rise;
        if (bus.drain_req && !bus.fill_req) begin
          nxt   = ST_DRAINING;
          tload = 1'b1;
          tval  = CNT_W'(DRAIN_CYCLES);
        end else if (tdone) begin
          nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        rej = outer_rise | bus.fill_req;
        if (bus.inner_req) begin
          nxt = ST_INNER_OPEN;
          rej = rej | bus.drain_req;
        end else if (bus.drain_req && !bus.fill_req) begin
          nxt   = ST_DRAINING;
          tload = 1'b1;
          tval  = CNT_W'(DRAIN_CYCLES);
        end else begin
          rej = rej | bus.drain_req;
        end
      end
      ST_INNER_OPEN: begin
        rej = bus.fill_req | bus.drain_req | outer_rise;
        if (!bus.inner_req) nxt = ST_FULL;
      end
      ST_DRAINING: begin
        rej = bus.drain_req | outer_rise | inner_rise;
        if (bus.fill_req && !bus.drain_req) begin
          nxt   = ST_FILLING;
          tload = 1'b1;
          tval  = CNT_W'(FILL_CYCLES);
        end else if (tdone) begin
          nxt = ST_EMPTY;
        end
      end
      default: nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_EMPTY;
      outer_q         <= 1'b0;
      inner_q         <= 1'b0;
      bus.outer_open  <= 1'b0;
      bus.inner_open  <= 1'b0;
      bus.pressurized <= 1'b0;
      bus.busy        <= 1'b0;
      bus.reject      <= 1'b0;
      bus.state       <= 3'd0;
    end else begin
      state           <= nxt;
      outer_q         <= bus.outer_req;
      inner_q         <= bus.inner_req;
      bus.outer_open  <= (nxt == ST_OUTER_OPEN);
      bus.inner_open  <= (nxt == ST_INNER_OPEN);
      bus.pressurized <= is_pressurized(nxt);
      bus.busy        <= is_busy(nxt);
      bus.reject      <= rej;
      bus.state       <= nxt;
    end
  end

  airlock_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tload),
    .load_val (tval),
    .count    (count),
    .done     (tdone)
  );

  assign bus.countdown = count;

endmodule
